// File: rtl/mem_master.sv
// -----------------------------------------------------------------------------
// mem_master
//
// CPU-side initiator for a single-port RAM that writes synchronously and reads
// combinationally. A byte or 16-bit word request from the core is turned into
// one or two RAM byte cycles, low byte first. Reads hold mem_rd for WAIT_CYCLES
// extra cycles before mem_q is sampled. The assembled read data is returned on
// rdata. Every output comes straight from a flop.
//
// Ports
//   clk     in   system clock, all state on the rising edge
//   reset   in   synchronous active-high reset, overrides everything
//   req     in   request strobe, only looked at while busy = 0
//   we      in   1 = write, 0 = read (sampled with req)
//   word    in   1 = two-byte access, 0 = single byte (sampled with req)
//   addr    in   start byte address (sampled with req)
//   wdata   in   write data, low byte goes to addr (sampled with req)
//   busy    out  access in progress, new requests are ignored
//   done    out  one-cycle pulse when the access completes
//   rdata   out  read result, valid from done until the next read completes
//   mem_a   out  RAM byte address
//   mem_d   out  RAM write data
//   mem_q   in   RAM read data, combinational from mem_a
//   mem_rd  out  RAM read enable
//   mem_wr  out  RAM write enable, RAM writes on the edge ending the cycle
// -----------------------------------------------------------------------------
module mem_master #(
   parameter int ADDR_BITS   = 15,
   parameter int DATA_BITS   = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req,
   input  logic                   we,
   input  logic                   word,
   input  logic [ADDR_BITS-1:0]   addr,
   input  logic [2*DATA_BITS-1:0] wdata,
   output logic                   busy,
   output logic                   done,
   output logic [2*DATA_BITS-1:0] rdata,
   output logic [ADDR_BITS-1:0]   mem_a,
   output logic [DATA_BITS-1:0]   mem_d,
   input  logic [DATA_BITS-1:0]   mem_q,
   output logic                   mem_rd,
   output logic                   mem_wr
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

   localparam logic [7:0]           WAIT_LD  = 8'(WAIT_CYCLES);
   localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

   // FSM state and the request latched at the accept edge.
   state_e                 state_q, state_d;
   logic                   word_q, word_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [2*DATA_BITS-1:0] wdata_q, wdata_d;
   logic                   idx_q, idx_d;
   logic [7:0]             cnt_q, cnt_d;

   // Output registers.
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [2*DATA_BITS-1:0] rdata_q, rdata_d;
   logic [ADDR_BITS-1:0]   mem_a_q, mem_a_d;
   logic [DATA_BITS-1:0]   mem_d_q, mem_d_d;
   logic                   mem_rd_q, mem_rd_d;
   logic                   mem_wr_q, mem_wr_d;

   // ---------------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every _d gets a default before the case statement. A path that
      // leaves one unassigned would infer a latch.
      state_d  = state_q;
      word_d   = word_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      rdata_d  = rdata_q;
      mem_a_d  = mem_a_q;
      mem_d_d  = mem_d_q;
      mem_rd_d = mem_rd_q;
      mem_wr_d = mem_wr_q;

      case (state_q)
         ST_IDLE: begin
            // The done cycle is spent in IDLE. A request that is present
            // during done is therefore accepted back-to-back.
            busy_d   = 1'b0;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
            mem_a_d  = '0;
            mem_d_d  = '0;
            if (req) begin
               word_d  = word;
               addr_d  = addr;
               wdata_d = wdata;
               idx_d   = 1'b0;
               cnt_d   = WAIT_LD;
               busy_d  = 1'b1;
               mem_a_d = addr;
               if (we) begin
                  state_d  = ST_WRITE;
                  mem_wr_d = 1'b1;
                  mem_d_d  = wdata[DATA_BITS-1:0];
               end else begin
                  state_d  = ST_READ;
                  mem_rd_d = 1'b1;
               end
            end
         end

         ST_READ: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (word_q && !idx_q) begin
               // Low byte captured. Move to the next address and wait again
               // with mem_rd still high.
               rdata_d[DATA_BITS-1:0] = mem_q;
               idx_d   = 1'b1;
               cnt_d   = WAIT_LD;
               mem_a_d = addr_q + ADDR_ONE;
            end else begin
               if (word_q) begin
                  rdata_d[2*DATA_BITS-1:DATA_BITS] = mem_q;
               end else begin
                  rdata_d = {{DATA_BITS{1'b0}}, mem_q};
               end
               state_d  = ST_IDLE;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               idx_d    = 1'b0;
               mem_rd_d = 1'b0;
               mem_a_d  = '0;
            end
         end

         ST_WRITE: begin
            if (word_q && !idx_q) begin
               // The address increment wraps modulo 2^ADDR_BITS.
               idx_d   = 1'b1;
               mem_a_d = addr_q + ADDR_ONE;
               mem_d_d = wdata_q[2*DATA_BITS-1:DATA_BITS];
            end else begin
               state_d  = ST_IDLE;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               idx_d    = 1'b0;
               mem_wr_d = 1'b0;
               mem_a_d  = '0;
               mem_d_d  = '0;
            end
         end

         default: begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
            mem_a_d  = '0;
            mem_d_d  = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register. Reset aborts any access in flight, so no further write
   // strobe and no done pulse is produced.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every flop update from values
      // sampled before the edge, whatever the statement order.
      if (reset) begin
         state_q  <= ST_IDLE;
         word_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         idx_q    <= 1'b0;
         cnt_q    <= 8'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rdata_q  <= '0;
         mem_a_q  <= '0;
         mem_d_q  <= '0;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rdata_q  <= rdata_d;
         mem_a_q  <= mem_a_d;
         mem_d_q  <= mem_d_d;
         mem_rd_q <= mem_rd_d;
         mem_wr_q <= mem_wr_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign rdata  = rdata_q;
   assign mem_a  = mem_a_q;
   assign mem_d  = mem_d_q;
   assign mem_rd = mem_rd_q;
   assign mem_wr = mem_wr_q;

   // Read and write strobes are mutually exclusive by construction.
   a_rd_wr_exclusive : assert property (@(posedge clk) disable iff (reset)
      !(mem_rd_q && mem_wr_q));

endmodule

// File: tb/tb_mem_master.sv
// -----------------------------------------------------------------------------
// tb_mem_master
//
// Two instances of mem_master are built. One uses WAIT_CYCLES=1 and the other
// uses WAIT_CYCLES=0. Each drives its own behavioural RAM. The two instances
// share the request inputs. The instance that is not under test is held in
// reset. Stimulus pushes the expected response of every access into a queue.
// A monitor process watches the selected instance. On every done it pops one
// entry and compares rdata, latency, and the number of mem_rd / mem_wr cycles.
// -----------------------------------------------------------------------------
module tb_mem_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, rst0, sel;
   logic        req, we, word;
   logic [14:0] addr;
   logic [15:0] wdata;

   logic        busy1, done1, mem_rd1, mem_wr1;
   logic [15:0] rdata1;
   logic [14:0] mem_a1;
   logic [7:0]  mem_d1, mem_q1;

   logic        busy0, done0, mem_rd0, mem_wr0;
   logic [15:0] rdata0;
   logic [14:0] mem_a0;
   logic [7:0]  mem_d0, mem_q0;

   mem_master #(.ADDR_BITS(15), .DATA_BITS(8), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(rst1), .req(req), .we(we), .word(word),
      .addr(addr), .wdata(wdata), .busy(busy1), .done(done1),
      .rdata(rdata1), .mem_a(mem_a1), .mem_d(mem_d1), .mem_q(mem_q1),
      .mem_rd(mem_rd1), .mem_wr(mem_wr1)
   );

   mem_master #(.ADDR_BITS(15), .DATA_BITS(8), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(rst0), .req(req), .we(we), .word(word),
      .addr(addr), .wdata(wdata), .busy(busy0), .done(done0),
      .rdata(rdata0), .mem_a(mem_a0), .mem_d(mem_d0), .mem_q(mem_q0),
      .mem_rd(mem_rd0), .mem_wr(mem_wr0)
   );

   // Behavioural RAMs: synchronous write, combinational read. ram1 also has a
   // preload port that the bench uses while its master is idle.
   logic [7:0]  ram1 [32768];
   logic [7:0]  ram0 [32768];
   logic        pl_we;
   logic [14:0] pl_a;
   logic [7:0]  pl_d;

   assign mem_q1 = ram1[mem_a1];
   assign mem_q0 = ram0[mem_a0];

   always @(posedge clk) begin
      if (mem_wr1)    ram1[mem_a1] <= mem_d1;
      else if (pl_we) ram1[pl_a]   <= pl_d;
      if (mem_wr0)    ram0[mem_a0] <= mem_d0;
   end

   // Outputs of the instance currently under test.
   logic        c_busy, c_done, c_mem_rd, c_mem_wr;
   logic [15:0] c_rdata;
   logic [14:0] c_mem_a;
   logic [7:0]  c_mem_d;

   assign c_busy   = sel ? busy0   : busy1;
   assign c_done   = sel ? done0   : done1;
   assign c_mem_rd = sel ? mem_rd0 : mem_rd1;
   assign c_mem_wr = sel ? mem_wr0 : mem_wr1;
   assign c_rdata  = sel ? rdata0  : rdata1;
   assign c_mem_a  = sel ? mem_a0  : mem_a1;
   assign c_mem_d  = sel ? mem_d0  : mem_d1;

   typedef struct {
      logic [15:0] rdata;
      int          lat;
      int          nrd;
      int          nwr;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------------------
   int   cyc = 0;
   int   start_cyc = 0;
   int   n_rd = 0;
   int   n_wr = 0;
   logic overlap = 1'b0;
   logic in_acc = 1'b0;
   exp_t mon_e;

   always @(negedge clk) begin
      cyc = cyc + 1;
      // busy dropping without done means the access was aborted by reset.
      if (in_acc && !c_busy && !c_done) in_acc = 1'b0;
      if (c_busy && !in_acc) begin
         in_acc    = 1'b1;
         start_cyc = cyc;
         n_rd      = 0;
         n_wr      = 0;
         overlap   = 1'b0;
      end
      if (in_acc) begin
         if (c_mem_rd) n_rd++;
         if (c_mem_wr) n_wr++;
         if (c_mem_rd && c_mem_wr) overlap = 1'b1;
      end
      if (c_done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("rdata",      32'(c_rdata), 32'(mon_e.rdata));
            check("latency",    32'(cyc - start_cyc + 1), 32'(mon_e.lat));
            check("rd_cycles",  32'(n_rd), 32'(mon_e.nrd));
            check("wr_cycles",  32'(n_wr), 32'(mon_e.nwr));
            check("rd_wr_excl", 32'(overlap), 32'd0);
            check("busy_at_done", 32'(c_busy), 32'd0);
         end
         in_acc = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (called right after a falling edge)
   // ---------------------------------------------------------------------------
   task automatic wait_done();
      int n = 0;
      while (!c_done && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!c_done) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_access(input logic w, input logic wd, input logic [14:0] a,
                            input logic [15:0] d, input logic [15:0] exp_rd,
                            input int lat, input int nrd, input int nwr);
      exp_t e;
      e.rdata = exp_rd;
      e.lat   = lat;
      e.nrd   = nrd;
      e.nwr   = nwr;
      exp_q.push_back(e);
      req   = 1'b1;
      we    = w;
      word  = wd;
      addr  = a;
      wdata = d;
      @(negedge clk);
      req = 1'b0;
      check("first_busy",   32'(c_busy), 32'd1);
      check("first_mem_a",  32'(c_mem_a), 32'(a));
      check("first_mem_rd", 32'(c_mem_rd), 32'(!w));
      check("first_mem_wr", 32'(c_mem_wr), 32'(w));
      if (w) check("first_mem_d", 32'(c_mem_d), 32'(d[7:0]));
      wait_done();
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      exp_t e;
      rst1 = 1'b1; rst0 = 1'b1; sel = 1'b0;
      req = 1'b0; we = 1'b0; word = 1'b0; addr = '0; wdata = '0;
      pl_we = 1'b0; pl_a = '0; pl_d = '0;

      repeat (3) @(negedge clk);
      check("rst_busy",   32'(busy1), 32'd0);
      check("rst_done",   32'(done1), 32'd0);
      check("rst_rdata",  32'(rdata1), 32'd0);
      check("rst_mem_a",  32'(mem_a1), 32'd0);
      check("rst_mem_rd", 32'(mem_rd1), 32'd0);
      check("rst_mem_wr", 32'(mem_wr1), 32'd0);
      rst1 = 1'b0;

      // WAIT_CYCLES = 1 instance.
      do_access(1'b1, 1'b0, 15'h0010, 16'h00A5, 16'h0000, 2, 0, 1);
      check("ram_10", 32'(ram1[15'h0010]), 32'h0A5);

      do_access(1'b1, 1'b1, 15'h0020, 16'hBEEF, 16'h0000, 3, 0, 2);
      check("ram_20", 32'(ram1[15'h0020]), 32'h0EF);
      check("ram_21", 32'(ram1[15'h0021]), 32'h0BE);

      do_access(1'b0, 1'b1, 15'h0020, 16'h0000, 16'hBEEF, 5, 4, 0);
      do_access(1'b0, 1'b0, 15'h0021, 16'h0000, 16'h00BE, 3, 2, 0);

      do_access(1'b1, 1'b1, 15'h7FFF, 16'h1234, 16'h00BE, 3, 0, 2);
      check("ram_7fff", 32'(ram1[15'h7FFF]), 32'h034);
      check("ram_0000", 32'(ram1[15'h0000]), 32'h012);

      do_access(1'b0, 1'b1, 15'h7FFF, 16'h0000, 16'h1234, 5, 4, 0);

      // Reset during the first byte of a word write.
      @(negedge clk);
      pl_we = 1'b1; pl_a = 15'h0040; pl_d = 8'hFF;
      @(negedge clk);
      pl_a = 15'h0041;
      @(negedge clk);
      pl_we = 1'b0;
      req = 1'b1; we = 1'b1; word = 1'b1; addr = 15'h0040; wdata = 16'h5566;
      @(negedge clk);
      req = 1'b0;
      check("abort_first_wr", 32'(mem_wr1), 32'd1);
      check("abort_first_d",  32'(mem_d1), 32'h066);
      rst1 = 1'b1;
      @(negedge clk);
      check("abort_busy",   32'(busy1), 32'd0);
      check("abort_done",   32'(done1), 32'd0);
      check("abort_rdata",  32'(rdata1), 32'd0);
      check("abort_mem_wr", 32'(mem_wr1), 32'd0);
      rst1 = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_ram_40", 32'(ram1[15'h0040]), 32'h066);
      check("abort_ram_41", 32'(ram1[15'h0041]), 32'h0FF);

      // Switch to the WAIT_CYCLES = 0 instance.
      rst1 = 1'b1;
      sel  = 1'b1;
      rst0 = 1'b0;
      @(negedge clk);

      do_access(1'b1, 1'b1, 15'h0000, 16'h2211, 16'h0000, 3, 0, 2);
      do_access(1'b1, 1'b0, 15'h0002, 16'h0033, 16'h0000, 2, 0, 1);

      // Three byte reads with req held high, each accepted in the previous
      // done cycle.
      for (int k = 0; k < 3; k++) begin
         e.rdata = 16'(k + 1) * 16'h0011;
         e.lat   = 2;
         e.nrd   = 1;
         e.nwr   = 0;
         exp_q.push_back(e);
      end
      req = 1'b1; we = 1'b0; word = 1'b0; addr = 15'h0000;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("b2b_accept", 32'(c_busy), 32'd1);
         check("b2b_mem_rd", 32'(c_mem_rd), 32'd1);
         if (k < 2) addr = 15'(k + 1);
         else       req  = 1'b0;
         @(negedge clk);
         check("b2b_done", 32'(c_done), 32'd1);
      end
      @(negedge clk);
      check("b2b_idle_after", 32'(c_busy), 32'd0);

      repeat (2) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- CPU-side initiator for the single-port synchronous-write / combinational-read RAM.
- Accepts byte or 16-bit word requests from the core over a req/busy/done handshake.
- Sequences them into one or two RAM byte cycles (little-endian), inserting configurable read wait states, and returns assembled read data.
- Sits between the instruction/data fetch logic and the RAM.

Parameters:
- ADDR_BITS, 15, RAM address width.
- DATA_BITS, 8, RAM data width (one byte cycle).
- WAIT_CYCLES, 1, extra cycles mem_rd is held before mem_q is sampled; range 0..255.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  1  request strobe, sampled only when busy=0
- we  input  1  1=write, 0=read; sampled with req
- word  input  1  1=two-byte access, 0=single byte; sampled with req
- addr  input  ADDR_BITS  start byte address; sampled with req
- wdata  input  2*DATA_BITS  write data, low byte at addr; sampled with req
- busy  output  1  access in progress, new req ignored
- done  output  1  one-cycle pulse, access complete
- rdata  output  2*DATA_BITS  read result, valid from done, held until next read completes
- mem_a  output  ADDR_BITS  RAM address
- mem_d  output  DATA_BITS  RAM write data
- mem_q  input  DATA_BITS  RAM read data (combinational from RAM)
- mem_rd  output  1  RAM read enable
- mem_wr  output  1  RAM write enable (RAM writes on the edge ending the cycle)

Behaviour:
- All outputs registered. States: IDLE, READ, WRITE. Internal: latched we/word/addr/wdata, byte index idx (0/1), wait counter cnt (8 bits).
- Reset (synchronous, wins over everything): next cycle state=IDLE, busy=0, done=0, rdata=0, mem_a=0, mem_d=0, mem_rd=0, mem_wr=0, idx=0, cnt=0.
- Reset mid-access aborts immediately: no further mem_wr. The second byte of a word write is not written. No done pulse.
- IDLE: busy=0, mem_rd=mem_wr=0, mem_a=0, mem_d=0.
  - On edge with req=1: latch the request, set idx=0, cnt=WAIT_CYCLES, busy=1.
  - Go to READ (we=0) or WRITE (we=1).
  - req is accepted in the same cycle done is high, giving back-to-back accesses.
- Byte address: mem_a = latched addr + idx, modulo 2^ADDR_BITS (addr all-ones, word access: second byte at 0).
- READ: mem_rd=1.
  - Each edge with cnt!=0: cnt decrements.
  - Edge with cnt==0: mem_q captured into rdata byte idx.
  - If word=1 and idx=0: idx becomes 1, cnt reloads WAIT_CYCLES, stay in READ (mem_rd stays high, mem_a advances).
  - Otherwise go to IDLE with done=1 for one cycle.
  - A byte read zeroes rdata[2*DATA_BITS-1:DATA_BITS].
  - mem_rd is high for exactly WAIT_CYCLES+1 cycles per byte.
- WRITE: mem_wr=1, mem_d = latched wdata byte idx, exactly one cycle per byte.
  - If word=1 and idx=0: idx becomes 1, stay in WRITE.
  - Otherwise go to IDLE with done=1.
  - rdata is unchanged by writes.
- mem_rd and mem_wr are never high together.
- Latency, counted from the req-accept edge to the done cycle, in cycles:
  - byte read: WAIT_CYCLES+2
  - word read: 2*WAIT_CYCLES+3
  - byte write: 2
  - word write: 3
- busy=1 in every cycle from the accept edge until the done cycle. busy=0 during done.
- Inputs change while busy=1: ignored. req held high continuously: a new access starts on every done cycle.

Test Plan:
- Reset; WAIT_CYCLES=1; byte write addr=0x0010 wdata=0x00A5 -> mem_wr high 1 cycle with mem_a=0x0010, mem_d=0xA5; done 2 cycles after accept; RAM[0x10]=0xA5.
- Word write addr=0x0020 wdata=0xBEEF, then word read addr=0x0020 -> RAM[0x20]=0xEF, RAM[0x21]=0xBE; mem_rd high 4 cycles (2 at 0x20, 2 at 0x21); done 5 cycles after accept; rdata=0xBEEF.
- Byte read of 0x0021 after rdata=0xBEEF -> rdata=0x00BE; done 3 cycles after accept.
- Word write addr=0x7FFF wdata=0x1234 -> RAM[0x7FFF]=0x34, RAM[0x0000]=0x12 (address wrap); word read at 0x7FFF returns 0x1234.
- req held high, WAIT_CYCLES=0, three byte reads 0x0,0x1,0x2 issued back-to-back -> each accepted in the previous done cycle; done every 2 cycles; mem_rd high 1 cycle per byte.
- Word write 0x5566 to 0x0040 (RAM pre-filled 0xFF) with reset asserted in the cycle the first byte is written -> RAM[0x40]=0x66, RAM[0x41]=0xFF; busy=0, done=0, rdata=0, mem_wr=0 next cycle.
